// File: rtl/nibble_pkg.sv
// nibble_pkg: shared constants, types and helpers for the nibble packer.
//   NIBBLE_W / NIBBLES / PAD  - nibble width, nibbles per word, fill value
//   nibble_t / word_t / count_t - data types for one nibble, a packed word, a fill count
//   pack_state_t               - packer FSM states
//   put_nibble()               - write one nibble into a word slot
package nibble_pkg;

  localparam int NIBBLE_W = 4;
  localparam int NIBBLES  = 4;
  localparam logic [3:0] PAD = 4'hF;

  typedef logic [3:0]  nibble_t;
  typedef logic [15:0] word_t;
  typedef logic [2:0]  count_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  // A word with every slot holding the fill value.
  localparam word_t PAD_WORD = {NIBBLES{PAD}};

  // Return w with slot idx replaced by n; the other slots are untouched.
  function automatic word_t put_nibble(word_t w, logic [1:0] idx, nibble_t n);
    word_t r;
    r = w;
    case (idx)
      2'd0:    r[3:0]   = n;
      2'd1:    r[7:4]   = n;
      2'd2:    r[11:8]  = n;
      2'd3:    r[15:12] = n;
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nibble_packer_word_slot.sv
// word_slot: single-entry valid/ready output register for a packed word.
//   clk, rst        - clock, asynchronous active-high reset
//   load            - capture load_word/load_count this edge (wins over drain)
//   load_word/count - word and nibble count to capture
//   drain_ready     - consumer accepts the held word this edge
//   valid/word/count- registered output entry
//   free            - slot can take a new word this edge (empty or draining)
module word_slot
  import nibble_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  word_t  load_word,
  input  count_t load_count,
  input  logic   drain_ready,
  output logic   valid,
  output word_t  word,
  output count_t count,
  output logic   free
);

  logic   valid_q, valid_d;
  word_t  word_q,  word_d;
  count_t count_q, count_d;

  // Next-state for the slot: a load refills it, a drain alone empties it,
  // the word/count keep their last value once drained.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    count_d = count_q;
    if (load) begin
      valid_d = 1'b1;
      word_d  = load_word;
      count_d = load_count;
    end else if (valid_q && drain_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      word_q  <= PAD_WORD;
      count_q <= 3'd0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign valid = valid_q;
  assign word  = word_q;
  assign count = count_q;
  assign free  = !valid_q || drain_ready;

endmodule

// File: rtl/nibble_packer.sv
// nibble_packer: packs a serial stream of 4-bit values into 16-bit words.
//   clk, rst            - clock, asynchronous active-high reset
//   in_data/valid/last  - upstream nibble stream; last ends a short packet
//   in_ready            - nibble accepted this cycle when in_valid is high
//   out_word/count/valid- packed word (nibble k at [4k+3:4k]), real nibble count
//   out_ready           - consumer takes the word this cycle
// Unwritten slots hold PAD. The assembly register plus the output slot give
// two words of buffering; HOLD means both are full and input stalls.
module nibble_packer
  import nibble_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] out_word,
  output logic [2:0]  out_count,
  output logic        out_valid,
  input  logic        out_ready
);

  pack_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  word_t       asm_q, asm_d;
  count_t      hold_cnt_q, hold_cnt_d;

  logic   slot_load;
  word_t  slot_word;
  count_t slot_count;
  logic   slot_free;

  logic   accept;
  logic   complete;
  word_t  filled;
  count_t fill_cnt;

  // in_ready is a function of state only, so out_ready never reaches it
  // combinationally.
  assign in_ready = (state_q == FILL) && !rst;
  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || (idx_q == 2'd3));
  assign filled   = put_nibble(asm_q, idx_q, in_data);
  assign fill_cnt = {1'b0, idx_q} + 3'd1;

  // Packing FSM: fill the assembly register, hand off to the output slot,
  // or park a finished word in HOLD while the slot is still occupied.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    hold_cnt_d = hold_cnt_q;
    slot_load  = 1'b0;
    slot_word  = asm_q;
    slot_count = hold_cnt_q;
    case (state_q)
      FILL: begin
        if (complete) begin
          idx_d = 2'd0;
          if (slot_free) begin
            slot_load  = 1'b1;
            slot_word  = filled;
            slot_count = fill_cnt;
            asm_d      = PAD_WORD;
          end else begin
            asm_d      = filled;
            hold_cnt_d = fill_cnt;
            state_d    = HOLD;
          end
        end else if (accept) begin
          asm_d = filled;
          idx_d = idx_q + 2'd1;
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        // Slot is necessarily valid here; a drain makes room for the parked word.
        if (out_valid && out_ready) begin
          slot_load  = 1'b1;
          slot_word  = asm_q;
          slot_count = hold_cnt_q;
          asm_d      = PAD_WORD;
          idx_d      = 2'd0;
          state_d    = FILL;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = 2'd0;
        asm_d   = PAD_WORD;
      end
    endcase
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      idx_q      <= 2'd0;
      asm_q      <= PAD_WORD;
      hold_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  word_slot u_slot (
    .clk         (clk),
    .rst         (rst),
    .load        (slot_load),
    .load_word   (slot_word),
    .load_count  (slot_count),
    .drain_ready (out_ready),
    .valid       (out_valid),
    .word        (out_word),
    .count       (out_count),
    .free        (slot_free)
  );

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Upstream stage of the 4-nibble sorting network: collects a serial stream of 4-bit values into one 16-bit word and presents it to the sorter's 16-bit input.
- Valid/ready handshake on both sides; supports short packets via a last flag.
- Unused slots are padded with the maximum nibble value, so padding sorts to the top nibbles.
- Two-entry buffering (assembly register plus output register) keeps input flowing while the consumer stalls.

Parameters:
- NIBBLE_W, 4, bits per nibble.
- NIBBLES, 4, nibbles per packed word.
- PAD, 4'hF, fill value for slots not written before in_last.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- in_data  in  4  nibble to pack.
- in_valid  in  1  in_data is valid.
- in_last  in  1  this nibble ends the packet; qualified by in_valid.
- in_ready  out  1  packer accepts a nibble this cycle.
- out_word  out  16  packed word; nibble k in bits [4k+3:4k].
- out_count  out  3  number of real nibbles in out_word, 1..4.
- out_valid  out  1  out_word/out_count are valid.
- out_ready  in  1  consumer takes the word this cycle.

Behaviour:
- Accept: in_valid && in_ready at a rising edge. Transfer: out_valid && out_ready at a rising edge.
- Reset (asynchronous, active-high):
  - state=FILL, fill index=0, assembly register = all PAD.
  - out_valid=0, out_word=16'hFFFF, out_count=0.
  - in_ready=0 while rst is high.
- Packing: the nibble accepted at fill index k is written to assembly bits [4k+3:4k]. The index increments and wraps to 0 after completion.
- Completion: occurs on accepting the 4th nibble, or any nibble with in_last=1. out_count is set to the index+1 of that final nibble. All slots above it are PAD.
- in_last on the 4th nibble is the same as normal completion; there is no extra empty word.
- State FILL: in_ready=1. On completion:
  - If the output slot is free (out_valid=0), or is being drained at this same edge: load out_word/out_count, out_valid=1 after the edge. The assembly register resets to PAD and the index to 0. Stay in FILL.
  - Else: keep the completed word in the assembly register and go to HOLD.
- State HOLD: in_ready=0. On a transfer edge, move the assembly word into the output register (out_valid stays 1), clear the assembly register to PAD and the index to 0, and go to FILL.
- Latency:
  - With the output free, out_valid rises on the edge that accepts the completing nibble (registered, 0 extra cycles).
  - Back-to-back full words give 1 word per 4 cycles with no bubbles.
- Output register: holds steady while out_valid && !out_ready. After a transfer with no new word, out_valid=0 and out_word/out_count keep their last value.
- Simultaneous completion and transfer in FILL: the new word replaces the drained one with no bubble; out_valid stays 1.
- in_valid=0 for any number of cycles mid-packet: partial contents are retained; there is no timeout.
- in_last with in_valid=0 is ignored.
- Reset mid-packet or mid-HOLD: all partial and buffered data is discarded. The first nibble after reset lands in slot 0.
- No combinational path from out_ready to in_ready except via state (in_ready depends only on state and rst).

Decomposition:
- Package nibble_pkg:
  - Constants NIBBLE_W, NIBBLES, PAD.
  - Typedefs nibble_t (logic [3:0]), word_t (logic [15:0]), count_t (logic [2:0]).
  - Enum pack_state_t {FILL, HOLD}.
- One sub-module, word_slot: a single-entry valid/ready output register holding word_t plus count_t, with load/drain and a free-or-draining indication. The packer owns the FSM, index counter and assembly register.

Test Plan:
- Full word, out_ready=1: nibbles 3,1,2,0 back-to-back -> out_word=16'h0213, out_count=4, out_valid high for exactly 1 cycle starting at the edge of the 4th accept.
- Short packet: nibble 5 with in_last=1 -> out_word=16'hFFF5, out_count=1. Then nibbles 7,8 (last on 8) -> out_word=16'hFF87, out_count=2.
- Backpressure: out_ready=0, feed 8 nibbles 0..7 ->
  - out_word=16'h3210 held; in_ready drops after the 8th accept (HOLD).
  - Raise out_ready for 2 cycles -> 16'h3210 then 16'h7654 in order, in_ready returns to 1 after the first transfer.
- Drain coincident with completion: out_valid=1 holding 16'hAAAA, complete 16'h4321 on the same edge out_ready=1 -> next cycle out_word=16'h4321, out_valid continuously 1.
- Reset mid-operation: accept 9,9, pulse rst asynchronously between edges -> out_valid=0 immediately. Then A,B,C,D -> out_word=16'hDCBA, count 4.
- Chained with the sorter: packed 16'hFF87 fed to the sorter -> sorter output 16'hFF87 (ascending 7,8,F,F from bits 3:0 upward). Compare against a software sort for 1000 random packets of random length.
